// File: rtl/riscv_trap_pkg.sv
// riscv_trap_pkg
// Shared encodings for the trap sequencer: PC-select values, the request
// kinds that can cause a redirect, the sequencer FSM states and small
// decode helpers used by both the priority resolver and the sequencer.
package riscv_trap_pkg;

    // Next-PC source selected by the frontend mux
    typedef enum logic [1:0] {
        PC_NORM = 2'b00,
        PC_TVEC = 2'b01,
        PC_MEPC = 2'b10,
        PC_SEPC = 2'b11
    } pcsel_e;

    // Kind of redirect request; NONE means nothing pending
    typedef enum logic [2:0] {
        KIND_NONE = 3'd0,
        KIND_EXC  = 3'd1,
        KIND_IRQ  = 3'd2,
        KIND_MRET = 3'd3,
        KIND_SRET = 3'd4
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int CNT_W = 4;

    // Trap entries go to the vector; returns go to the saved epc
    function automatic pcsel_e kind_to_pcsel(kind_e k);
        case (k)
            KIND_EXC, KIND_IRQ: return PC_TVEC;
            KIND_MRET:          return PC_MEPC;
            KIND_SRET:          return PC_SEPC;
            default:            return PC_NORM;
        endcase
    endfunction

    // Only trap entries update cause/epc/status
    function automatic logic kind_is_entry(kind_e k);
        return (k == KIND_EXC) || (k == KIND_IRQ);
    endfunction

endpackage

// File: rtl/riscv_trap_prio.sv
// riscv_trap_prio
// Combinational fixed-priority resolver for simultaneous redirect requests:
// exception > interrupt > mret > sret.
// Ports:
//   gototrap_i  exception at commit
//   irq_i       pending enabled interrupt
//   ret_i       trap return request (1 = mret, 2 = sret, 0/3 = none)
//   kind_o      winning request kind, KIND_NONE when nothing requested
module riscv_trap_prio
    import riscv_trap_pkg::*;
(
    input  logic       gototrap_i,
    input  logic       irq_i,
    input  logic [1:0] ret_i,
    output kind_e      kind_o
);

    always_comb begin
        kind_o = KIND_NONE;
        if (gototrap_i)          kind_o = KIND_EXC;
        else if (irq_i)          kind_o = KIND_IRQ;
        else if (ret_i == 2'd1)  kind_o = KIND_MRET;
        else if (ret_i == 2'd2)  kind_o = KIND_SRET;
    end

endmodule

// File: rtl/riscv_trap_seq.sv
// riscv_trap_seq
// Trap/return redirect sequencer. Accepts exception, interrupt and trap
// return requests, waits while the frontend is stalled, then issues a
// redirect: one cycle of pcsel (+ CSR write for trap entries) together with
// a flush that is held for FLUSH_CYCLES cycles. All outputs are registered.
// Ports:
//   i_riscv_trapseq_clk            clock
//   i_riscv_trapseq_rst            synchronous active-high reset
//   i_riscv_trapseq_gototrap       exception at commit
//   i_riscv_trapseq_irq            pending enabled interrupt
//   i_riscv_trapseq_returnfromtrap 1 = mret, 2 = sret, 0/3 = none
//   i_riscv_trapseq_icache_stall   frontend cannot take a redirect
//   o_riscv_trapseq_flush          flush earlier pipeline stages
//   o_riscv_trapseq_pcsel          next-PC source
//   o_riscv_trapseq_csr_we         trap-entry CSR commit pulse
//   o_riscv_trapseq_is_irq         qualifies csr_we: interrupt entry
//   o_riscv_trapseq_busy           sequencer not idle
module riscv_trap_seq
    import riscv_trap_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       i_riscv_trapseq_clk,
    input  logic       i_riscv_trapseq_rst,
    input  logic       i_riscv_trapseq_gototrap,
    input  logic       i_riscv_trapseq_irq,
    input  logic [1:0] i_riscv_trapseq_returnfromtrap,
    input  logic       i_riscv_trapseq_icache_stall,
    output logic       o_riscv_trapseq_flush,
    output logic [1:0] o_riscv_trapseq_pcsel,
    output logic       o_riscv_trapseq_csr_we,
    output logic       o_riscv_trapseq_is_irq,
    output logic       o_riscv_trapseq_busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_e           state_q, state_d;
    kind_e            kind_q, kind_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush_q, flush_d;
    pcsel_e           pcsel_q, pcsel_d;
    logic             csr_we_q, csr_we_d;
    logic             is_irq_q, is_irq_d;
    logic             busy_q, busy_d;

    kind_e            req_kind;
    kind_e            fire_kind;

    riscv_trap_prio u_prio (
        .gototrap_i (i_riscv_trapseq_gototrap),
        .irq_i      (i_riscv_trapseq_irq),
        .ret_i      (i_riscv_trapseq_returnfromtrap),
        .kind_o     (req_kind)
    );

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        fire_kind = KIND_NONE;
        flush_d   = 1'b0;
        pcsel_d   = PC_NORM;
        csr_we_d  = 1'b0;
        is_irq_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_kind != KIND_NONE) begin
                    if (i_riscv_trapseq_icache_stall) begin
                        state_d = ST_WAIT;
                        kind_d  = req_kind;
                    end else begin
                        fire_kind = req_kind;
                    end
                end
            end
            ST_WAIT: begin
                // A fresh exception is more urgent than whatever is parked;
                // other new requests are dropped while a redirect is pending.
                if (i_riscv_trapseq_gototrap) kind_d = KIND_EXC;
                if (!i_riscv_trapseq_icache_stall) fire_kind = kind_d;
            end
            ST_FLUSH: begin
                // Requests here come from instructions being flushed.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    kind_d  = KIND_NONE;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                kind_d  = KIND_NONE;
            end
        endcase

        // Redirect launch: pcsel/csr_we only on this first flush cycle
        if (fire_kind != KIND_NONE) begin
            state_d  = ST_FLUSH;
            kind_d   = fire_kind;
            cnt_d    = CNT_LOAD;
            flush_d  = 1'b1;
            pcsel_d  = kind_to_pcsel(fire_kind);
            csr_we_d = kind_is_entry(fire_kind);
            is_irq_d = (fire_kind == KIND_IRQ);
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_riscv_trapseq_clk) begin
        if (i_riscv_trapseq_rst) begin
            state_q  <= ST_IDLE;
            kind_q   <= KIND_NONE;
            cnt_q    <= '0;
            flush_q  <= 1'b0;
            pcsel_q  <= PC_NORM;
            csr_we_q <= 1'b0;
            is_irq_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
            pcsel_q  <= pcsel_d;
            csr_we_q <= csr_we_d;
            is_irq_q <= is_irq_d;
            busy_q   <= busy_d;
        end
    end

    assign o_riscv_trapseq_flush  = flush_q;
    assign o_riscv_trapseq_pcsel  = pcsel_q;
    assign o_riscv_trapseq_csr_we = csr_we_q;
    assign o_riscv_trapseq_is_irq = is_irq_q;
    assign o_riscv_trapseq_busy   = busy_q;

endmodule

// File: tb/tb_riscv_trap_seq.sv
// tb_riscv_trap_seq
// Two sequencers (FLUSH_CYCLES = 2 and 4) share one stimulus stream. Each
// is compared every cycle against a behavioural reference, and the directed
// scenarios additionally check fixed expected output vectors.
// Output vectors are packed as {busy, is_irq, csr_we, flush, pcsel[1:0]}.
module tb_riscv_trap_seq;

    logic       clk = 1'b0;
    logic       rst, exc, irq, stall;
    logic [1:0] ret;

    logic       f2, c2, i2, b2, f4, c4, i4, b4;
    logic [1:0] p2, p4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    riscv_trap_seq #(.FLUSH_CYCLES(2)) dut2 (
        .i_riscv_trapseq_clk            (clk),
        .i_riscv_trapseq_rst            (rst),
        .i_riscv_trapseq_gototrap       (exc),
        .i_riscv_trapseq_irq            (irq),
        .i_riscv_trapseq_returnfromtrap (ret),
        .i_riscv_trapseq_icache_stall   (stall),
        .o_riscv_trapseq_flush          (f2),
        .o_riscv_trapseq_pcsel          (p2),
        .o_riscv_trapseq_csr_we         (c2),
        .o_riscv_trapseq_is_irq         (i2),
        .o_riscv_trapseq_busy           (b2)
    );

    riscv_trap_seq #(.FLUSH_CYCLES(4)) dut4 (
        .i_riscv_trapseq_clk            (clk),
        .i_riscv_trapseq_rst            (rst),
        .i_riscv_trapseq_gototrap       (exc),
        .i_riscv_trapseq_irq            (irq),
        .i_riscv_trapseq_returnfromtrap (ret),
        .i_riscv_trapseq_icache_stall   (stall),
        .o_riscv_trapseq_flush          (f4),
        .o_riscv_trapseq_pcsel          (p4),
        .o_riscv_trapseq_csr_we         (c4),
        .o_riscv_trapseq_is_irq         (i4),
        .o_riscv_trapseq_busy           (b4)
    );

    // Reference: pend = parked request kind (0 none, 1 exc, 2 irq, 3 mret,
    // 4 sret); rem = flush cycles still owed after the one on display.
    typedef struct {
        int         pend;
        int         rem;
        logic       flush;
        logic [1:0] pcsel;
        logic       csr;
        logic       irq;
        logic       busy;
    } mdl_t;

    mdl_t m2, m4;

    function automatic int prio(logic e, logic i, logic [1:0] rt);
        if (e)        return 1;
        if (i)        return 2;
        if (rt == 1)  return 3;
        if (rt == 2)  return 4;
        return 0;
    endfunction

    function automatic mdl_t step(mdl_t m, int fc, logic r, logic e,
                                  logic i, logic [1:0] rt, logic st);
        mdl_t n;
        int   k;
        n       = m;
        n.flush = 1'b0;
        n.pcsel = 2'b00;
        n.csr   = 1'b0;
        n.irq   = 1'b0;
        k       = 0;
        if (r) begin
            n.pend = 0;
            n.rem  = 0;
            n.busy = 1'b0;
            return n;
        end
        if (m.flush) begin
            // while a flush is showing, every request is ignored
            if (m.rem > 0) begin
                n.flush = 1'b1;
                n.rem   = m.rem - 1;
            end
        end else if (m.pend != 0) begin
            if (e) n.pend = 1;
            if (!st) begin
                k      = n.pend;
                n.pend = 0;
            end
        end else if (st) begin
            n.pend = prio(e, i, rt);
        end else begin
            k = prio(e, i, rt);
        end
        if (k != 0) begin
            n.flush = 1'b1;
            n.rem   = fc - 1;
            n.pcsel = (k <= 2) ? 2'b01 : ((k == 3) ? 2'b10 : 2'b11);
            n.csr   = (k <= 2);
            n.irq   = (k == 2);
        end
        n.busy = n.flush || (n.pend != 0);
        return n;
    endfunction

    function automatic logic [5:0] mpack(mdl_t m);
        return {m.busy, m.irq, m.csr, m.flush, m.pcsel};
    endfunction

    function automatic logic [5:0] d2v();
        return {b2, i2, c2, f2, p2};
    endfunction

    function automatic logic [5:0] d4v();
        return {b4, i4, c4, f4, p4};
    endfunction

    task automatic chk(string tag, logic [5:0] obs, logic [5:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: advance both references with the inputs seen at the edge,
    // then sample the DUTs just after it.
    task automatic cyc(string tag);
        @(posedge clk);
        m2 = step(m2, 2, rst, exc, irq, ret, stall);
        m4 = step(m4, 4, rst, exc, irq, ret, stall);
        #1;
        chk({tag, "/fc2"}, d2v(), mpack(m2));
        chk({tag, "/fc4"}, d4v(), mpack(m4));
    endtask

    task automatic quiet(int n);
        exc = 0; irq = 0; ret = 0; stall = 0;
        for (int q = 0; q < n; q++) cyc("quiet");
    endtask

    initial begin
        m2 = '{0, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        m4 = m2;
        rst = 1; exc = 0; irq = 0; ret = 0; stall = 0;

        // reset, with a request present that must be discarded
        irq = 1;
        cyc("reset");
        chk("reset_fc2", d2v(), 6'b000000);
        chk("reset_fc4", d4v(), 6'b000000);
        rst = 0;
        quiet(2);

        // exception, no stall: 2 flush cycles, pcsel/csr_we only on first
        exc = 1;
        cyc("exc_entry");
        chk("exc_entry", d2v(), 6'b101101);
        exc = 0;
        cyc("exc_flush2");
        chk("exc_flush2", d2v(), 6'b100100);
        cyc("exc_done");
        chk("exc_done", d2v(), 6'b000000);
        quiet(5);

        // interrupt beats mret
        irq = 1; ret = 2'd1;
        cyc("irq_vs_mret");
        chk("irq_vs_mret", d2v(), 6'b111101);
        quiet(6);

        // mret held off by stall for 3 cycles
        ret = 2'd1; stall = 1;
        cyc("mret_wait1");
        chk("mret_wait1", d2v(), 6'b100000);
        ret = 2'd0;
        cyc("mret_wait2");
        chk("mret_wait2", d2v(), 6'b100000);
        cyc("mret_wait3");
        chk("mret_wait3", d2v(), 6'b100000);
        stall = 0;
        cyc("mret_go");
        chk("mret_go", d2v(), 6'b100110);
        quiet(6);

        // parked interrupt replaced by a later exception
        irq = 1; stall = 1;
        cyc("irq_park");
        irq = 0; exc = 1;
        cyc("exc_replace");
        exc = 0;
        cyc("replace_hold");
        chk("replace_hold", d2v(), 6'b100000);
        stall = 0;
        cyc("replace_go");
        chk("replace_go", d2v(), 6'b101101);
        quiet(6);

        // reset on the second flush cycle, request right after reset
        exc = 1;
        cyc("rst_mid_entry");
        exc = 0;
        cyc("rst_mid_flush2");
        rst = 1; irq = 1;
        cyc("rst_mid");
        chk("rst_mid_fc2", d2v(), 6'b000000);
        chk("rst_mid_fc4", d4v(), 6'b000000);
        rst = 0; irq = 0; exc = 1;
        cyc("post_rst");
        chk("post_rst", d2v(), 6'b101101);
        quiet(6);

        // sret on the 4-cycle instance; requests during flush are ignored
        ret = 2'd2;
        cyc("sret_entry");
        chk("sret_entry", d4v(), 6'b100111);
        ret = 2'd0; exc = 1; irq = 1;
        for (int j = 0; j < 3; j++) begin
            cyc("sret_flush");
            chk("sret_flush", d4v(), 6'b100100);
        end
        cyc("sret_done");
        chk("sret_done", d4v(), 6'b000000);
        quiet(6);

        // random traffic against the reference
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 39) == 0);
            exc   = ($urandom_range(0, 7) == 0);
            irq   = ($urandom_range(0, 5) == 0);
            ret   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            stall = $urandom_range(0, 1) == 1;
            cyc("rand");
        end
        quiet(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
